// File: rtl/parallel_to_serial_if.sv
// Link-side byte handshake, bit-rate strobe and serial outputs of the USB TX serializer.
// master = link layer / bit-strobe source, slave = parallel_to_serial.
interface parallel_to_serial_if #(
   parameter int PARALLEL_WIDTH = 8
);
   logic [PARALLEL_WIDTH-1:0] data;
   logic                      valid;
   logic                      last;
   logic                      ready;
   logic                      bit_en;
   logic                      ser_data;
   logic                      ser_valid;
   logic                      sync_pattern;
   logic                      busy;
   logic                      error;

   modport master (
      output data, valid, last, bit_en,
      input  ready, ser_data, ser_valid, sync_pattern, busy, error
   );

   modport slave (
      input  data, valid, last, bit_en,
      output ready, ser_data, ser_valid, sync_pattern, busy, error
   );
endinterface

// File: rtl/parallel_to_serial.sv
// USB TX serializer: holding register + MSB-first shifter, one bit per bit_en strobe.
// Optional SYNC prefix per packet is compiled in with `define P2S_SYNC_GEN_EN.
module parallel_to_serial #(
   parameter int                    PARALLEL_WIDTH = 8,
   parameter int                    SYNC_WIDTH     = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN   = 8'b0000_0001
) (
   input logic                  clk,
   input logic                  rst_n,
   parallel_to_serial_if.slave  bus
);

   localparam int MAX_W = (PARALLEL_WIDTH > SYNC_WIDTH) ? PARALLEL_WIDTH : SYNC_WIDTH;
   localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DATA = 2'd2;
`ifdef P2S_SYNC_GEN_EN
   localparam logic [1:0] SYNC = 2'd1;
   localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(SYNC_WIDTH - 1);
`endif
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(PARALLEL_WIDTH - 1);

   logic [1:0]                state_reg, state_next;
   logic [PARALLEL_WIDTH-1:0] hold_data_reg, hold_data_next;
   logic                      hold_last_reg, hold_last_next;
   logic                      hold_full_reg, hold_full_next;
   logic [PARALLEL_WIDTH-1:0] shift_reg, shift_next;
   logic                      cur_last_reg, cur_last_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic                      ser_data_reg, ser_data_next;
   logic                      ser_valid_reg, ser_valid_next;
   logic                      sync_flag_reg, sync_flag_next;
   logic                      busy_reg, busy_next;
   logic                      error_reg, error_next;
   logic                      accept;

   assign accept = bus.valid && !hold_full_reg;

   always_comb begin
      state_next     = state_reg;
      hold_data_next = hold_data_reg;
      hold_last_next = hold_last_reg;
      hold_full_next = hold_full_reg;
      shift_next     = shift_reg;
      cur_last_next  = cur_last_reg;
      cnt_next       = cnt_reg;
      ser_data_next  = ser_data_reg;
      ser_valid_next = 1'b0;
      sync_flag_next = 1'b0;
      error_next     = error_reg;

      if (accept) begin
         hold_data_next = bus.data;
         hold_last_next = bus.last;
         hold_full_next = 1'b1;
      end

      case (state_reg)
         IDLE: begin
            // A byte kept in hold from the previous packet starts the next one too.
            if (accept || hold_full_reg) begin
               if (accept) begin
                  error_next = 1'b0;
               end
               cnt_next = '0;
`ifdef P2S_SYNC_GEN_EN
               state_next = SYNC;
`else
               state_next     = DATA;
               hold_full_next = 1'b0;
               if (hold_full_reg) begin
                  shift_next    = hold_data_reg;
                  cur_last_next = hold_last_reg;
               end else begin
                  shift_next    = bus.data;
                  cur_last_next = bus.last;
               end
`endif
            end
         end
`ifdef P2S_SYNC_GEN_EN
         SYNC: begin
            if (bus.bit_en) begin
               ser_valid_next = 1'b1;
               ser_data_next  = SYNC_PATTERN[LAST_SYNC - cnt_reg];
               sync_flag_next = 1'b1;
               if (cnt_reg == LAST_SYNC) begin
                  shift_next     = hold_data_reg;
                  cur_last_next  = hold_last_reg;
                  hold_full_next = accept;
                  cnt_next       = '0;
                  state_next     = DATA;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
`endif
         DATA: begin
            if (bus.bit_en) begin
               ser_valid_next = 1'b1;
               ser_data_next  = shift_reg[PARALLEL_WIDTH-1];
               shift_next     = {shift_reg[PARALLEL_WIDTH-2:0], 1'b0};
               cnt_next       = cnt_reg + 1'b1;
               if (cnt_reg == LAST_DATA) begin
                  cnt_next = '0;
                  if (cur_last_reg) begin
                     state_next = IDLE;
                  end else if (hold_full_reg) begin
                     // Back-to-back reload: the next byte's MSB goes out on the very next strobe.
                     shift_next     = hold_data_reg;
                     cur_last_next  = hold_last_reg;
                     hold_full_next = accept;
                  end else begin
                     error_next = 1'b1;
                     state_next = IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy_next = (state_next != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         hold_data_reg <= '0;
         hold_last_reg <= 1'b0;
         hold_full_reg <= 1'b0;
         shift_reg     <= '0;
         cur_last_reg  <= 1'b0;
         cnt_reg       <= '0;
         ser_data_reg  <= 1'b0;
         ser_valid_reg <= 1'b0;
         sync_flag_reg <= 1'b0;
         busy_reg      <= 1'b0;
         error_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         hold_data_reg <= hold_data_next;
         hold_last_reg <= hold_last_next;
         hold_full_reg <= hold_full_next;
         shift_reg     <= shift_next;
         cur_last_reg  <= cur_last_next;
         cnt_reg       <= cnt_next;
         ser_data_reg  <= ser_data_next;
         ser_valid_reg <= ser_valid_next;
         sync_flag_reg <= sync_flag_next;
         busy_reg      <= busy_next;
         error_reg     <= error_next;
      end
   end

`ifndef P2S_SYNC_GEN_EN
   logic unused_sync_cfg;
   assign unused_sync_cfg = ^SYNC_PATTERN;
`endif

   assign bus.ready        = !hold_full_reg;
   assign bus.ser_data     = ser_data_reg;
   assign bus.ser_valid    = ser_valid_reg;
   assign bus.sync_pattern = sync_flag_reg;
   assign bus.busy         = busy_reg;
   assign bus.error        = error_reg;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Randomized bench for parallel_to_serial: a bit-queue model of each packet's serial stream
// is compared with the DUT on every falling edge; directed packets pin the model with literals.
`timescale 1ns/1ps
module tb_parallel_to_serial;
   localparam int             PW  = 8;
   localparam int             SW  = 8;
   localparam logic [SW-1:0]  SP  = 8'b0000_0001;
   localparam int             LIM = 3000;
`ifdef P2S_SYNC_GEN_EN
   localparam int             PRE = SW;
`else
   localparam int             PRE = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   parallel_to_serial_if #(.PARALLEL_WIDTH(PW)) bus ();

   parallel_to_serial #(
      .PARALLEL_WIDTH(PW),
      .SYNC_WIDTH    (SW),
      .SYNC_PATTERN  (SP)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // ---------------- behavioural model ----------------
   logic [1:0]  bits_q[$];   // {sync flag, bit} still to be emitted by the active packet
   logic [PW:0] byte_q[$];   // {last, data} accepted but not yet being shifted
   logic        m_active, m_cur_last, m_err;
   int          m_sync_left;
   logic        exp_valid, exp_data, exp_sync;

   logic [63:0] cap = '0;
   int          nvalid = 0;
   int          nsync = 0;
   int          run = 0;
   int          last_run = 0;

   task automatic model_reset();
      bits_q.delete();
      byte_q.delete();
      m_active = 1'b0; m_cur_last = 1'b0; m_err = 1'b0; m_sync_left = 0;
      exp_valid = 1'b0; exp_data = 1'b0; exp_sync = 1'b0;
   endtask

   task automatic push_byte_bits(input logic [PW:0] e);
      for (int i = PW - 1; i >= 0; i--) bits_q.push_back({1'b0, e[i]});
      m_cur_last = e[PW];
   endtask

   task automatic start_packet();
      logic [PW:0]   e;
      logic [SW-1:0] sp_v;
      sp_v = SP;
      e = byte_q.pop_front();
      bits_q.delete();
      m_sync_left = PRE;
      for (int i = PRE - 1; i >= 0; i--) bits_q.push_back({1'b1, sp_v[i]});
      push_byte_bits(e);
      m_active = 1'b1;
   endtask

   // Advance the model over the coming rising edge using the inputs stable now.
   task automatic model_step();
      logic       was;
      logic [1:0] b;
      was = m_active;
      exp_valid = 1'b0;
      exp_sync  = 1'b0;
      if (was && bus.bit_en) begin
         b = bits_q.pop_front();
         exp_valid = 1'b1;
         exp_data  = b[0];
         exp_sync  = b[1];
         if (b[1]) m_sync_left--;
         if (bits_q.size() == 0) begin
            if (m_cur_last) m_active = 1'b0;
            else if (byte_q.size() > 0) push_byte_bits(byte_q.pop_front());
            else begin
               m_err = 1'b1;
               m_active = 1'b0;
            end
         end
      end
      if (bus.valid && bus.ready) begin
         byte_q.push_back({bus.last, bus.data});
         if (!was) m_err = 1'b0;
      end
      if (!was && byte_q.size() > 0) start_packet();
   endtask

   initial model_reset();

   always @(negedge clk) begin
      if (!rst_n) model_reset();
      check("ser_valid", {63'd0, bus.ser_valid}, {63'd0, exp_valid});
      if (exp_valid) check("ser_data", {63'd0, bus.ser_data}, {63'd0, exp_data});
      check("sync_pattern", {63'd0, bus.sync_pattern}, {63'd0, exp_sync});
      check("busy", {63'd0, bus.busy}, {63'd0, m_active});
      check("error", {63'd0, bus.error}, {63'd0, m_err});
      check("ready", {63'd0, bus.ready},
            {63'd0, !(byte_q.size() > 0 || m_sync_left > 0)});
      if (bus.ser_valid) begin
         cap = {cap[62:0], bus.ser_data};
         nvalid++;
         run++;
         if (bus.sync_pattern) nsync++;
      end else if (run != 0) begin
         last_run = run;
         run = 0;
      end
      if (rst_n) model_step();
   end

   // ---------------- stimulus ----------------
   int ben_mode = 0;  // 0: every cycle, 1: every 4th cycle, 2: random

   initial begin
      int ph;
      ph = 0;
      bus.bit_en = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         ph++;
         case (ben_mode)
            0:       bus.bit_en = 1'b1;
            1:       bus.bit_en = (ph % 4 == 0);
            default: bus.bit_en = ($urandom_range(0, 2) == 0);
         endcase
      end
   end

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic send_byte(input logic [PW-1:0] d, input logic l);
      int t;
      t = 0;
      bus.data  = d;
      bus.last  = l;
      bus.valid = 1'b1;
      @(negedge clk);
      while (!bus.ready && t < LIM) begin
         @(negedge clk);
         t++;
      end
      check("handshake_timeout", {63'd0, (t < LIM)}, 64'd1);
      @(posedge clk);
      #2;
      bus.valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      idle_cycles(2);
      while ((bus.busy || bus.ser_valid || !bus.ready) && t < LIM) begin
         idle_cycles(1);
         t++;
      end
      check("idle_timeout", {63'd0, (t < LIM)}, 64'd1);
      idle_cycles(2);
   endtask

   initial begin
      int base, sbase, n, t, len, gap;
      logic [7:0] d;
      bus.data = '0; bus.last = 1'b0; bus.valid = 1'b0;
      idle_cycles(3);
      check("rst_ready", {63'd0, bus.ready}, 64'd1);
      check("rst_busy", {63'd0, bus.busy}, 64'd0);
      rst_n = 1'b1;
      idle_cycles(2);

      // Single byte A5
      ben_mode = 0;
      base = nvalid; sbase = nsync;
      send_byte(8'hA5, 1'b1);
      wait_idle();
      $display("txn single A5: %0d bits", nvalid - base);
      check("a5_count", 64'(nvalid - base), 64'(PRE + 8));
      check("a5_sync_count", 64'(nsync - sbase), 64'(PRE));
`ifdef P2S_SYNC_GEN_EN
      check("a5_bits", {48'd0, cap[15:0]}, 64'h01A5);
`else
      check("a5_bits", {56'd0, cap[7:0]}, 64'hA5);
`endif
      check("a5_error", {63'd0, bus.error}, 64'd0);

      // Three-byte packet, continuous strobe and every-4th strobe
      for (int m = 0; m < 2; m++) begin
         ben_mode = m;
         base = nvalid;
         send_byte(8'h01, 1'b0);
         send_byte(8'hFF, 1'b0);
         send_byte(8'h80, 1'b1);
         wait_idle();
         $display("txn three-byte mode %0d: %0d bits", m, nvalid - base);
         check("p3_count", 64'(nvalid - base), 64'(PRE + 24));
`ifdef P2S_SYNC_GEN_EN
         check("p3_bits", {32'd0, cap[31:0]}, 64'h0101FF80);
`else
         check("p3_bits", {40'd0, cap[23:0]}, 64'h01FF80);
`endif
         if (m == 0) check("p3_no_gap", 64'(last_run), 64'(PRE + 24));
      end

      // Underrun, then a new byte clears the error
      ben_mode = 0;
      base = nvalid;
      send_byte(8'h3C, 1'b0);
      wait_idle();
      $display("txn underrun 3C: %0d bits", nvalid - base);
      check("ur_error", {63'd0, bus.error}, 64'd1);
      check("ur_busy", {63'd0, bus.busy}, 64'd0);
      check("ur_count", 64'(nvalid - base), 64'(PRE + 8));
      send_byte(8'h11, 1'b1);
      check("ur_clear", {63'd0, bus.error}, 64'd0);
      wait_idle();

      // Reset on the 11th strobe, then a clean packet
      base = nvalid;
      send_byte(8'h96, 1'b0);
      send_byte(8'h69, 1'b1);
      t = 0;
      n = nvalid - base + int'(bus.ser_valid);
      while (n < 11 && t < LIM) begin
         idle_cycles(1);
         n = nvalid - base + int'(bus.ser_valid);
         t++;
      end
      check("rst11_reached", 64'(n), 64'd11);
      rst_n = 1'b0;
      #1;
      check("rst11_valid", {63'd0, bus.ser_valid}, 64'd0);
      check("rst11_data", {63'd0, bus.ser_data}, 64'd0);
      check("rst11_sync", {63'd0, bus.sync_pattern}, 64'd0);
      check("rst11_busy", {63'd0, bus.busy}, 64'd0);
      check("rst11_ready", {63'd0, bus.ready}, 64'd1);
      idle_cycles(2);
      rst_n = 1'b1;
      idle_cycles(2);
      base = nvalid;
      send_byte(8'h5A, 1'b1);
      wait_idle();
      $display("txn after reset 5A: %0d bits", nvalid - base);
`ifdef P2S_SYNC_GEN_EN
      check("5a_bits", {48'd0, cap[15:0]}, 64'h015A);
`else
      check("5a_bits", {56'd0, cap[7:0]}, 64'h5A);
`endif

      // C3: first data bit is 1, sync flag only during the prefix
      base = nvalid; sbase = nsync;
      send_byte(8'hC3, 1'b1);
      wait_idle();
      $display("txn single C3: %0d bits", nvalid - base);
      check("c3_first_bit", {63'd0, cap[7]}, 64'd1);
      check("c3_bits", {56'd0, cap[7:0]}, 64'hC3);
      check("c3_sync_count", 64'(nsync - sbase), 64'(PRE));

      // Randomized packets with random strobe density and inter-byte gaps
      for (int p = 0; p < 150; p++) begin
         ben_mode = $urandom_range(0, 2);
         len = $urandom_range(1, 4);
         base = nvalid;
         for (int b = 0; b < len; b++) begin
            d = 8'($urandom_range(0, 255));
            gap = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 3);
            idle_cycles(gap);
            send_byte(d, (b == len - 1));
         end
         if ($urandom_range(0, 3) == 0) wait_idle();
         $display("txn random pkt %0d len %0d mode %0d", p, len, ben_mode);
      end
      wait_idle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Transmit-side serializer for the USB 2.0 PHY datapath. It accepts packet bytes from the link layer over a valid/ready handshake, optionally prefixes each packet with a SYNC field, and shifts every byte out MSB-first, one bit per bit-rate strobe. Its bit order and SYNC framing match the PHY's receive deserializer, so a loopback reassembles the original bytes. Its serial output feeds the bit-stuffer/NRZI encoder.

## Interface
- PARALLEL_WIDTH, 8: byte width of the parallel input.
- SYNC_WIDTH, 8: number of SYNC bits sent before the first byte.
- SYNC_PATTERN, 8'b0000_0001: SYNC bits, sent MSB-first; width SYNC_WIDTH.
- i_clk  input  1  single clock for all logic.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_data  input  PARALLEL_WIDTH  byte to transmit.
- i_valid  input  1  i_data/i_last valid.
- i_last  input  1  qualifies i_data as the final byte of the packet.
- o_ready  output  1  holding register empty; the byte transfers on i_valid && o_ready.
- i_bit_en  input  1  bit-rate strobe; one serial bit advances per strobe.
- o_data  output  1  serial bit.
- o_valid  output  1  one-cycle strobe qualifying o_data.
- o_sync_pattern  output  1  high with o_valid while SYNC bits are emitted.
- o_busy  output  1  state != IDLE.
- o_error  output  1  sticky underrun flag.

## Operation
- Storage: a holding register (byte + last flag + full bit) and a shift register with a bit counter of $clog2(max(PARALLEL_WIDTH, SYNC_WIDTH)) bits.
- o_ready = !hold_full. Also high in IDLE after an error.
- FSM states: IDLE, SYNC, DATA.
- IDLE: an accepted byte sets hold_full and clears o_error. Next state is SYNC, or DATA when SYNC generation is compiled out.
- SYNC: each i_bit_en emits SYNC_PATTERN[SYNC_WIDTH-1-cnt] with o_valid=1 and o_sync_pattern=1. On the strobe carrying the last SYNC bit:
  - the shift register loads from hold;
  - hold_full clears;
  - the FSM moves to DATA.
- DATA: each i_bit_en emits shift MSB, shifts left and increments the count.
- DATA, last bit (count == PARALLEL_WIDTH-1) with i_bit_en, current byte's last flag set: go to IDLE. Any hold contents are kept for the next packet.
- DATA, last bit with i_bit_en, last flag clear and hold_full: reload the shift register from hold, clear hold_full, reset the count. There is no gap bit.
- DATA, last bit with i_bit_en, last flag clear and !hold_full: underrun. Set o_error and go to IDLE.
- Hold accept and hold drain in the same cycle: the drain takes the old byte and the new byte fills hold. hold_full stays 1.
- i_bit_en outside SYNC/DATA is ignored. o_valid is never asserted in IDLE.

## Timing
- Reset values: o_data=0, o_valid=0, o_sync_pattern=0, o_busy=0, o_error=0, o_ready=1. FSM=IDLE, hold_full=0, count=0.
- All outputs are registered except o_ready, which is a combinational decode of hold_full.
- The byte accepted at edge N enters SYNC or DATA at edge N. The first o_valid appears at the edge after the first i_bit_en sampled at edge N+1 or later.
- Each o_valid is one cycle wide, on the edge that sampled i_bit_en=1.
- The byte boundary costs no bit-slot as long as the next byte is accepted before the final bit's strobe.
- Reset mid-packet: all state returns to reset values immediately and the partial byte is discarded.

## Configuration
- P2S_SYNC_GEN_EN defined: the SYNC state is present and every packet starts with SYNC_WIDTH bits of SYNC_PATTERN, flagged by o_sync_pattern.
- P2S_SYNC_GEN_EN undefined:
  - the SYNC state is removed;
  - IDLE goes directly to DATA;
  - o_sync_pattern is tied to 0;
  - SYNC_WIDTH and SYNC_PATTERN are unused.

## Test plan
- Single byte 8'hA5 with last=1, i_bit_en held high, macro on: o_data over 16 strobes = 0000_0001 then 1010_0101. o_sync_pattern high for the first 8 only. Return to IDLE; o_error=0.
- Three-byte packet 8'h01, 8'hFF, 8'h80, each presented as soon as o_ready rises: 32 consecutive o_valid cycles with no gap. The bytes appear MSB-first in order.
- i_bit_en every 4th cycle: o_valid occurs only on strobe edges. The bit count and values are the same as the continuous case.
- Byte 8'h3C with last=0, then no further byte: after 16 strobes o_error=1 and o_busy=0. A new accepted byte clears o_error.
- Reset asserted at the 11th strobe of a packet: all outputs go to reset values. A following single byte 8'h5A transmits cleanly.
- Macro off, byte 8'hC3 with last=1: the first strobe emits 1 and 8 bits total follow (1100_0011). o_sync_pattern stays 0.
